// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder: word alignment via control-token hunting with
// bitslip requests, then video/control decode. Optional error counter: TMDS_DEC_ERR_CNT_EN.
`timescale 1ns/1ps

module tmds_decoder #(
  parameter int CHANNEL        = 0,
  parameter int LOCK_CNT       = 64,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int SLIP_WAIT      = 4
) (
  input  logic       pixel_clk,
  input  logic       n_rst,
  input  logic [9:0] data_in,
  output logic       bitslip,
  output logic       aligned,
  output logic       active_video,
  output logic       d_0,
  output logic       d_1,
  output logic [7:0] data_out
`ifdef TMDS_DEC_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int RunW  = $clog2(LOCK_CNT + 1);
  localparam int ToW   = $clog2(SEARCH_TIMEOUT + 1);
  localparam int WaitW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  localparam logic [RunW-1:0]  RunMax   = RunW'(LOCK_CNT);
  localparam logic [ToW-1:0]   ToMax    = ToW'(SEARCH_TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SLIP_WAIT - 1);

  if (LOCK_CNT < 2 || LOCK_CNT > 255 || SLIP_WAIT < 1 ||
      SEARCH_TIMEOUT <= 800 || CHANNEL < 0) begin : g_param_check
    $error("tmds_decoder: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_SEARCH,
    S_SLIP,
    S_SLIP_WAIT,
    S_LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [ToW-1:0]   timeout_q, timeout_d;
  logic [WaitW-1:0] wait_q;

  logic       bitslip_q;
  logic       aligned_q;
  logic       av_q;
  logic [1:0] ctrl_q;
  logic [7:0] data_q;

  logic       is_token;
  logic [1:0] ctrl;
  logic [7:0] d_word;
  logic [7:0] q_word;

  always_comb begin
    is_token = 1'b1;
    ctrl     = 2'b00;
    case (data_in)
      10'b1101010100: ctrl = 2'b00;
      10'b0010101011: ctrl = 2'b01;
      10'b0101010100: ctrl = 2'b10;
      10'b1010101011: ctrl = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  // bit 8 selects XOR (1) or XNOR (0) chaining of adjacent bits
  always_comb begin
    d_word = data_in[9] ? ~data_in[7:0] : data_in[7:0];
    q_word = {d_word[7:1] ^ d_word[6:0] ^ {7{~data_in[8]}}, d_word[0]};
  end

  always_comb begin
    run_d     = '0;
    timeout_d = '0;
    if (is_token) begin
      run_d = (run_q == RunMax) ? run_q : run_q + RunW'(1);
    end else begin
      timeout_d = (timeout_q == ToMax) ? timeout_q : timeout_q + ToW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEARCH: begin
        if (run_d == RunMax)         state_d = S_LOCKED;
        else if (timeout_d == ToMax) state_d = S_SLIP;
      end
      S_SLIP:      state_d = S_SLIP_WAIT;
      S_SLIP_WAIT: if (wait_q == WaitLast) state_d = S_SEARCH;
      S_LOCKED:    if (timeout_d == ToMax) state_d = S_SEARCH;
      default:     state_d = S_SEARCH;
    endcase
  end

`ifdef TMDS_DEC_ERR_CNT_EN
  logic [15:0] err_q;
`endif

  // Output qualification follows the next state so that aligned and the
  // decoded outputs switch on the same edge in both directions.
  always_ff @(posedge pixel_clk) begin
    if (!n_rst) begin
      state_q   <= S_SEARCH;
      run_q     <= '0;
      timeout_q <= '0;
      wait_q    <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      av_q      <= 1'b0;
      ctrl_q    <= '0;
      data_q    <= '0;
`ifdef TMDS_DEC_ERR_CNT_EN
      err_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bitslip_q <= (state_d == S_SLIP);
      aligned_q <= (state_d == S_LOCKED);

      if (state_d != state_q) begin
        run_q     <= '0;
        timeout_q <= '0;
        wait_q    <= '0;
      end else begin
        case (state_q)
          S_SEARCH: begin
            run_q     <= run_d;
            timeout_q <= timeout_d;
          end
          S_LOCKED:    timeout_q <= timeout_d;
          S_SLIP_WAIT: wait_q    <= wait_q + WaitW'(1);
          default: ;
        endcase
      end

      if (state_d == S_LOCKED) begin
        av_q <= ~is_token;
        if (is_token) ctrl_q <= ctrl;
        else          data_q <= q_word;
      end else begin
        av_q   <= 1'b0;
        ctrl_q <= '0;
        data_q <= '0;
      end

`ifdef TMDS_DEC_ERR_CNT_EN
      if (state_q == S_LOCKED && data_in[9:8] == 2'b00 && !is_token && err_q != '1)
        err_q <= err_q + 16'd1;
`endif
    end
  end

  assign bitslip      = bitslip_q;
  assign aligned      = aligned_q;
  assign active_video = av_q;
  assign d_0          = ctrl_q[0];
  assign d_1          = ctrl_q[1];
  assign data_out     = data_q;
`ifdef TMDS_DEC_ERR_CNT_EN
  assign err_count    = err_q;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: random stimulus against a token-table
// and encoder-inversion reference model.
`timescale 1ns/1ps

module tb_tmds_decoder;

  localparam int LOCK_CNT       = 64;
  localparam int SEARCH_TIMEOUT = 1024;
  localparam int SLIP_WAIT      = 4;

  localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic       clk = 1'b0;
  logic       n_rst;
  logic [9:0] data_in;
  logic       bitslip, aligned, active_video, d_0, d_1;
  logic [7:0] data_out;
`ifdef TMDS_DEC_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic       exp_av;
  logic [1:0] exp_d;
  logic [7:0] exp_data;
  int         exp_err;

  tmds_decoder #(
    .CHANNEL(0),
    .LOCK_CNT(LOCK_CNT),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .pixel_clk(clk),
    .n_rst(n_rst),
    .data_in(data_in),
    .bitslip(bitslip),
    .aligned(aligned),
    .active_video(active_video),
    .d_0(d_0),
    .d_1(d_1),
    .data_out(data_out)
`ifdef TMDS_DEC_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int tok_index(input logic [9:0] w);
    tok_index = -1;
    for (int i = 0; i < 4; i++) if (TOK[i] == w) tok_index = i;
  endfunction

  // Inverts the transmit encoder by trying every byte through its
  // transition-minimising stage.
  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] target, qm, b;
    target = w[9] ? ~w[7:0] : w[7:0];
    ref_decode = '0;
    for (int c = 0; c < 256; c++) begin
      b = 8'(c);
      qm[0] = b[0];
      for (int i = 1; i < 8; i++)
        qm[i] = w[8] ? (qm[i-1] ^ b[i]) : ~(qm[i-1] ^ b[i]);
      if (qm == target) ref_decode = b;
    end
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    while (tok_index(w) >= 0) w = 10'($urandom_range(0, 1023));
    return w;
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int off);
    logic [19:0] x;
    x = {w, w} >> (10 - off);
    return x[9:0];
  endfunction

  task automatic do_reset();
    n_rst   = 1'b0;
    data_in = 10'($urandom_range(0, 1023));
    tick();
    tick();
    n_rst    = 1'b1;
    exp_av   = 1'b0;
    exp_d    = 2'b00;
    exp_data = 8'h00;
    exp_err  = 0;
  endtask

  task automatic lock_with(input int idx);
    for (int i = 0; i < LOCK_CNT; i++) begin
      data_in = TOK[idx];
      tick();
    end
    exp_av = 1'b0;
    exp_d  = 2'(idx);
    checks++;
    if ({aligned, active_video, d_1, d_0} !== {1'b1, 1'b0, exp_d}) begin
      failures++;
      $display("FAIL lock_with: got aligned/av/d=%b expected %b",
               {aligned, active_video, d_1, d_0}, {1'b1, 1'b0, exp_d});
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_in = 10'($urandom_range(0, 1023));
      tick();
      checks++;
      if ({bitslip, aligned, active_video, d_1, d_0, data_out} !== 13'h0) begin
        failures++;
        $display("FAIL reset_outputs: got %h expected 0",
                 {bitslip, aligned, active_video, d_1, d_0, data_out});
      end
`ifdef TMDS_DEC_ERR_CNT_EN
      checks++;
      if (err_count !== 16'h0) begin
        failures++;
        $display("FAIL reset_err: got %0d expected 0", err_count);
      end
`endif
    end
    n_rst = 1'b1;
    for (int i = 0; i < LOCK_CNT - 1; i++) begin
      data_in = 10'($urandom_range(0, 1023));
      tick();
      checks++;
      if (aligned !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_aligned: cycle %0d got %b expected 0", i, aligned);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < LOCK_CNT - 1; i++) begin
      data_in = TOK[0];
      tick();
    end
    data_in = 10'h155;
    tick();
    checks++;
    if (aligned !== 1'b0) begin
      failures++;
      $display("FAIL short_run: got aligned=%b expected 0", aligned);
    end
    for (int i = 0; i < LOCK_CNT; i++) begin
      data_in = TOK[3];
      tick();
      if (i == LOCK_CNT - 2) begin
        checks++;
        if (aligned !== 1'b0) begin
          failures++;
          $display("FAIL early_lock: got aligned=%b expected 0", aligned);
        end
      end
    end
    checks++;
    if ({aligned, active_video, d_1, d_0, data_out} !== {4'b1011, 8'h00}) begin
      failures++;
      $display("FAIL lock_edge: got %h expected %h",
               {aligned, active_video, d_1, d_0, data_out}, {4'b1011, 8'h00});
    end
    tick();
    checks++;
    if ({aligned, active_video, d_1, d_0} !== 4'b1011) begin
      failures++;
      $display("FAIL lock_hold: got %b expected 1011", {aligned, active_video, d_1, d_0});
    end
  endtask

  task automatic test_slip();
    int off = 3, pulses = 0, last = -1, cyc = 0, gap_bad = 0, consec = 0;
    logic prev_bs = 1'b0;
    do_reset();
    while (aligned !== 1'b1 && cyc < 6000) begin
      data_in = rotl(TOK[3], off);
      tick();
      cyc++;
      if (bitslip === 1'b1) begin
        if (prev_bs) consec++;
        if (last >= 0 && cyc - last < SEARCH_TIMEOUT + SLIP_WAIT + 1) gap_bad++;
        last = cyc;
        pulses++;
        off = (off > 0) ? off - 1 : 9;
      end
      prev_bs = bitslip;
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL slip_count: got %0d expected 3", pulses);
    end
    checks++;
    if (gap_bad != 0) begin
      failures++;
      $display("FAIL slip_spacing: got %0d short gaps expected 0", gap_bad);
    end
    checks++;
    if (consec != 0) begin
      failures++;
      $display("FAIL slip_consecutive: got %0d expected 0", consec);
    end
    checks++;
    if (aligned !== 1'b1 || off != 0) begin
      failures++;
      $display("FAIL slip_lock: got aligned=%b offset=%0d expected 1 and 0", aligned, off);
    end
  endtask

  task automatic test_decode();
    logic [9:0] fixed [2];
    logic [9:0] w;
    int idx;
    fixed[0] = 10'h1FF;
    fixed[1] = 10'h100;
    do_reset();
    lock_with(3);
    for (int k = 0; k < 2; k++) begin
      data_in = fixed[k];
      tick();
      exp_av   = 1'b1;
      exp_data = ref_decode(fixed[k]);
      checks++;
      if ({active_video, d_1, d_0, data_out} !== {exp_av, exp_d, exp_data}) begin
        failures++;
        $display("FAIL decode_fixed %h: got %h expected %h", fixed[k],
                 {active_video, d_1, d_0, data_out}, {exp_av, exp_d, exp_data});
      end
    end
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx    = int'($urandom_range(0, 3));
        w      = TOK[idx];
        exp_av = 1'b0;
        exp_d  = 2'(idx);
      end else begin
        w        = rand_data();
        exp_av   = 1'b1;
        exp_data = ref_decode(w);
        if (w[9:8] == 2'b00) exp_err++;
      end
      data_in = w;
      tick();
      checks++;
      if ({aligned, active_video, d_1, d_0, data_out} !== {1'b1, exp_av, exp_d, exp_data}) begin
        failures++;
        $display("FAIL decode_random %h: got %h expected %h", w,
                 {aligned, active_video, d_1, d_0, data_out}, {1'b1, exp_av, exp_d, exp_data});
      end
    end
`ifdef TMDS_DEC_ERR_CNT_EN
    checks++;
    if (err_count !== 16'(exp_err)) begin
      failures++;
      $display("FAIL decode_err: got %0d expected %0d", err_count, exp_err);
    end
`endif
  endtask

  task automatic test_loss();
    logic [9:0] w;
    int bad_bs = 0;
    do_reset();
    lock_with(1);
    for (int i = 1; i <= SEARCH_TIMEOUT; i++) begin
      w = rand_data();
      if (w[9:8] == 2'b00) exp_err++;
      data_in = w;
      tick();
      if (bitslip !== 1'b0) bad_bs++;
      checks++;
      if (i < SEARCH_TIMEOUT) begin
        if ({aligned, active_video, data_out} !== {2'b11, ref_decode(w)}) begin
          failures++;
          $display("FAIL locked_data %0d: got %h expected %h", i,
                   {aligned, active_video, data_out}, {2'b11, ref_decode(w)});
        end
      end else if ({aligned, active_video, d_1, d_0, data_out} !== 12'h0) begin
        failures++;
        $display("FAIL loss_edge: got %h expected 0",
                 {aligned, active_video, d_1, d_0, data_out});
      end
    end
    data_in = rand_data();
    tick();
    if (bitslip !== 1'b0) bad_bs++;
    checks++;
    if ({aligned, active_video} !== 2'b00) begin
      failures++;
      $display("FAIL after_loss: got %b expected 00", {aligned, active_video});
    end
    checks++;
    if (bad_bs != 0) begin
      failures++;
      $display("FAIL loss_bitslip: got %0d pulses expected 0", bad_bs);
    end
`ifdef TMDS_DEC_ERR_CNT_EN
    checks++;
    if (err_count !== 16'(exp_err)) begin
      failures++;
      $display("FAIL loss_err_hold: got %0d expected %0d", err_count, exp_err);
    end
`endif
    lock_with(2);
  endtask

  task automatic test_reset_midop();
    int cyc = 0, bad_bs = 0;
    do_reset();
    while (bitslip !== 1'b1 && cyc < 2000) begin
      data_in = rand_data();
      tick();
      cyc++;
    end
    checks++;
    if (bitslip !== 1'b1) begin
      failures++;
      $display("FAIL slip_seen: got no pulse in %0d cycles expected one", cyc);
    end
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = rand_data();
      if (bitslip !== 1'b0) bad_bs++;
      tick();
    end
    checks++;
    if (bad_bs != 0) begin
      failures++;
      $display("FAIL reset_midslip: got %0d pulses expected 0", bad_bs);
    end
    for (int i = 0; i < 40; i++) begin
      data_in = TOK[0];
      tick();
    end
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < LOCK_CNT - 1; i++) begin
      data_in = TOK[0];
      tick();
    end
    checks++;
    if (aligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_midlock: got aligned=%b expected 0", aligned);
    end
    data_in = TOK[0];
    tick();
    checks++;
    if (aligned !== 1'b1) begin
      failures++;
      $display("FAIL relock_after_reset: got aligned=%b expected 1", aligned);
    end
  endtask

`ifdef TMDS_DEC_ERR_CNT_EN
  task automatic test_err_count();
    do_reset();
    lock_with(3);
    for (int i = 0; i < 5; i++) begin
      data_in = 10'h0AA;
      tick();
    end
    data_in = TOK[3];
    tick();
    checks++;
    if (err_count !== 16'd5) begin
      failures++;
      $display("FAIL err_five: got %0d expected 5", err_count);
    end
    n_rst   = 1'b0;
    data_in = 10'h0AA;
    tick();
    n_rst = 1'b1;
    checks++;
    if ({err_count, aligned} !== 17'h0) begin
      failures++;
      $display("FAIL err_reset: got err=%0d aligned=%b expected 0 and 0", err_count, aligned);
    end
  endtask
`endif

  initial begin
    n_rst   = 1'b0;
    data_in = '0;
    exp_av   = 1'b0;
    exp_d    = 2'b00;
    exp_data = 8'h00;
    exp_err  = 0;
    test_reset();
    test_lock();
    test_slip();
    test_decode();
    test_loss();
    test_reset_midop();
`ifdef TMDS_DEC_ERR_CNT_EN
    test_err_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
